// File: rtl/uart_tx.sv
// uart_tx: UART transmitter with one-byte holding register and CTS-gated frame start
module uart_tx #(
   parameter int BIT_RATE     = 9600,
   parameter int CLK_HZ       = 50_000_000,
   parameter int PAYLOAD_BITS = 8,
   parameter int STOP_BITS    = 1,
   parameter int USE_CTS      = 1
)(
   input  logic                    clk,
   input  logic                    resetn,
   output logic                    uart_txd,
   input  logic                    uart_cts,
   input  logic                    uart_tx_start,
   input  logic [PAYLOAD_BITS-1:0] uart_tx_data,
   output logic                    uart_tx_ready,
   output logic                    uart_tx_busy
);
   localparam int CYCLES_PER_BIT = (CLK_HZ-1)/BIT_RATE;
   localparam int COUNT_REG_LEN  = 1+$clog2(CYCLES_PER_BIT);
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   state_t state, state_nxt;
   logic [COUNT_REG_LEN-1:0] cnt, cnt_nxt;
   logic [3:0] idx, idx_nxt;
   logic [PAYLOAD_BITS-1:0] shift, shift_nxt, hold, hold_nxt;
   logic hold_valid, hold_valid_nxt, txd_nxt;
   logic [1:0] cts_sync;
   logic cts_ok, bit_end, last_stop, launch;
   assign uart_tx_ready = !hold_valid;
   assign uart_tx_busy  = (state != IDLE) || hold_valid;
   always_comb begin
      cts_ok         = (USE_CTS == 0) || !cts_sync[1];
      bit_end        = cnt == COUNT_REG_LEN'(CYCLES_PER_BIT);
      last_stop      = state == STOP && bit_end && idx == 4'(STOP_BITS-1);
      launch         = hold_valid && cts_ok && (state == IDLE || last_stop);
      state_nxt      = state;
      cnt_nxt        = (state == IDLE || bit_end) ? '0 : cnt + COUNT_REG_LEN'(1);
      idx_nxt        = idx;
      shift_nxt      = shift;
      hold_nxt       = hold;
      hold_valid_nxt = hold_valid;
      txd_nxt        = uart_txd;
      if (uart_tx_start && !hold_valid) begin
         hold_nxt       = uart_tx_data;
         hold_valid_nxt = 1'b1;
      end
      if (launch) begin
         state_nxt      = START;
         cnt_nxt        = '0;
         shift_nxt      = hold;
         hold_valid_nxt = 1'b0;
         txd_nxt        = 1'b0;
      end else if (bit_end) begin
         case (state)
            START: begin
               state_nxt = DATA;
               idx_nxt   = '0;
               txd_nxt   = shift[0];
            end
            DATA: begin
               if (idx == 4'(PAYLOAD_BITS-1)) begin
                  state_nxt = STOP;
                  idx_nxt   = '0;
                  txd_nxt   = 1'b1;
               end else begin
                  idx_nxt   = idx + 4'd1;
                  shift_nxt = shift >> 1;
                  txd_nxt   = shift_nxt[0];
               end
            end
            STOP: begin
               state_nxt = last_stop ? IDLE : STOP;
               idx_nxt   = last_stop ? '0 : idx + 4'd1;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state      <= IDLE;
         cnt        <= '0;
         idx        <= '0;
         shift      <= '0;
         hold       <= '0;
         hold_valid <= 1'b0;
         uart_txd   <= 1'b1;
         cts_sync   <= 2'b11;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         idx        <= idx_nxt;
         shift      <= shift_nxt;
         hold       <= hold_nxt;
         hold_valid <= hold_valid_nxt;
         uart_txd   <= txd_nxt;
         cts_sync   <= {cts_sync[0], uart_cts};
      end
   end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed and randomized checks of uart_tx against a per-bit line model
module tb_uart_tx;
   localparam int BIT_CLKS = 9, FRAME_BITS = 10;
   logic clk = 0, resetn = 0, uart_cts = 0, uart_tx_start = 0;
   logic [7:0] uart_tx_data = 0;
   logic uart_txd, uart_tx_ready, uart_tx_busy;
   int vectors = 0, errs = 0;

   uart_tx #(.BIT_RATE(10), .CLK_HZ(81), .PAYLOAD_BITS(8), .STOP_BITS(1), .USE_CTS(1)) dut (
      .clk(clk), .resetn(resetn), .uart_txd(uart_txd), .uart_cts(uart_cts),
      .uart_tx_start(uart_tx_start), .uart_tx_data(uart_tx_data),
      .uart_tx_ready(uart_tx_ready), .uart_tx_busy(uart_tx_busy));

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: got %b expected %b", tag, obs, exp);
      end
   endtask

   // expected line level for frame bit b: start, 8 data bits LSB first, stop
   function automatic logic line_bit(input logic [7:0] d, input int b);
      return b == 0 ? 1'b0 : (b <= 8 ? d[b-1] : 1'b1);
   endfunction

   task automatic chk_idle(input string tag);
      chk({tag, " txd"}, uart_txd, 1'b1);
      chk({tag, " ready"}, uart_tx_ready, 1'b1);
      chk({tag, " busy"}, uart_tx_busy, 1'b0);
   endtask

   task automatic write_idle(input logic [7:0] d);
      uart_tx_start = 1;
      uart_tx_data  = d;
      tick;
      uart_tx_start = 0;
      chk("ready after E0", uart_tx_ready, 1'b0);
      chk("txd at E0", uart_txd, 1'b1);
      chk("busy at E0", uart_tx_busy, 1'b1);
      tick;
   endtask

   // Called just after the start-bit edge; walks the whole frame cycle by cycle.
   task automatic frame_chk(input logic [7:0] d, input bit wr, input logic [7:0] wd,
                            input int cts_at, input int rst_at);
      for (int k = 0; k < BIT_CLKS*FRAME_BITS; k++) begin
         chk($sformatf("txd %02h k=%0d", d, k), uart_txd, line_bit(d, k/BIT_CLKS));
         chk($sformatf("ready k=%0d", k), uart_tx_ready, !(wr && k >= 1));
         chk($sformatf("busy k=%0d", k), uart_tx_busy, 1'b1);
         if (k == rst_at) begin
            resetn = 0;
            tick;
            return;
         end
         uart_tx_start = wr && (k == 0 || k == 5);
         uart_tx_data  = (k == 5) ? ~wd : wd;
         if (k == cts_at) uart_cts = 1;
         tick;
      end
   endtask

   initial begin
      logic [7:0] b [24];
      logic [7:0] q;
      repeat (3) tick;
      chk_idle("reset");
      resetn = 1;
      tick;
      chk_idle("after release");
      // 1: single frame
      write_idle(8'hA5);
      frame_chk(8'hA5, 0, 8'h00, -1, -1);
      chk_idle("end A5");
      // 2: back-to-back pair, second written as soon as ready rises
      q = 8'($urandom);
      write_idle(8'h3C);
      frame_chk(8'h3C, 1, 8'hC3, -1, -1);
      frame_chk(8'hC3, 0, 8'h00, -1, -1);
      chk_idle("end pair");
      // 3: CTS held off, byte waits
      uart_cts = 1;
      repeat (3) tick;
      q = 8'h55;
      uart_tx_start = 1;
      uart_tx_data  = q;
      tick;
      for (int i = 0; i < 20; i++) begin
         uart_tx_start = (i == 3);
         uart_tx_data  = (i == 3) ? ~q : q;
         chk("cts wait txd", uart_txd, 1'b1);
         chk("cts wait ready", uart_tx_ready, 1'b0);
         chk("cts wait busy", uart_tx_busy, 1'b1);
         tick;
      end
      uart_tx_start = 0;
      uart_cts = 0;
      tick;
      chk("cts sync1 txd", uart_txd, 1'b1);
      tick;
      chk("cts sync2 txd", uart_txd, 1'b1);
      tick;
      frame_chk(q, 0, 8'h00, -1, -1);
      chk_idle("end cts");
      // 4: CTS raised mid-frame; queued byte waits for CTS low
      q = 8'($urandom);
      write_idle(8'hFF);
      frame_chk(8'hFF, 1, q, 40, -1);
      for (int i = 0; i < 12; i++) begin
         chk("queued txd", uart_txd, 1'b1);
         chk("queued ready", uart_tx_ready, 1'b0);
         chk("queued busy", uart_tx_busy, 1'b1);
         tick;
      end
      uart_cts = 0;
      tick;
      tick;
      chk("requeue sync txd", uart_txd, 1'b1);
      tick;
      frame_chk(q, 0, 8'h00, -1, -1);
      chk_idle("end midcts");
      // 5: reset during DATA3 with a byte held
      write_idle(8'h81);
      frame_chk(8'h81, 1, 8'($urandom), -1, 38);
      chk_idle("mid-frame reset");
      resetn = 1;
      for (int i = 0; i < 100; i++) begin
         tick;
         chk("post-reset txd", uart_txd, 1'b1);
         chk("post-reset busy", uart_tx_busy, 1'b0);
      end
      // 6: random back-to-back stream with dropped strobes
      foreach (b[i]) b[i] = 8'($urandom);
      write_idle(b[0]);
      for (int i = 0; i < 24; i++)
         frame_chk(b[i], i < 23, (i < 23) ? b[(i+1) % 24] : 8'h00, -1, -1);
      chk_idle("end stream");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
